// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues in-order BRAM reads, absorbs read latency
// in a credit-limited skid buffer and presents {instruction, pc} to the queue.
module fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned BUF_DEPTH    = 4,
  parameter int unsigned IMEM_WORDS   = 4096
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  output logic [$clog2(IMEM_WORDS)-1:0] imem_addr_out,
  output logic                          imem_en_out,
  input  logic [31:0]                   imem_data_in,
  input  logic                          iq_ready_in,
  output logic                          valid_out,
  output logic [31:0]                   instruction_out,
  output logic [31:0]                   pc_out,
  input  logic                          redirect_in,
  input  logic [31:0]                   redirect_pc_in
);

  localparam int unsigned ADDR_W = $clog2(IMEM_WORDS);
  localparam int unsigned PTR_W  = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W  = $clog2(BUF_DEPTH + READ_LATENCY + 1) + 1;

  logic [31:0]             fetch_pc_q, fetch_pc_d;
  logic [READ_LATENCY-1:0] slot_v_q;
  logic [31:0]             slot_pc_q [READ_LATENCY];
  logic [31:0]             buf_data_q [BUF_DEPTH];
  logic [31:0]             buf_pc_q [BUF_DEPTH];
  logic [PTR_W-1:0]        head_q, tail_q;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [CNT_W-1:0]        inflight;
  logic                    pop, push, issue;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit check counts buffered plus in-flight entries, net of this cycle's pop
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(READ_LATENCY); i++) begin
      inflight = inflight + CNT_W'(slot_v_q[i]);
    end
    valid_out       = (count_q != '0) && !redirect_in && !rst_in;
    pop             = valid_out && iq_ready_in;
    push            = slot_v_q[READ_LATENCY-1];
    issue           = !rst_in && !redirect_in &&
                      ((count_q + inflight - CNT_W'(pop)) < CNT_W'(BUF_DEPTH));
    imem_en_out     = issue;
    imem_addr_out   = rst_in ? RESET_PC[ADDR_W+1:2] : fetch_pc_q[ADDR_W+1:2];
    instruction_out = buf_data_q[head_q];
    pc_out          = buf_pc_q[head_q];
    fetch_pc_d      = issue ? fetch_pc_q + 32'd4 : fetch_pc_q;
    count_d         = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      slot_v_q   <= '0;
      for (int i = 0; i < int'(READ_LATENCY); i++) slot_pc_q[i] <= '0;
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        buf_data_q[i] <= '0;
        buf_pc_q[i]   <= '0;
      end
    end else if (redirect_in) begin
      // Drop everything; reads already issued return into invalid slots
      fetch_pc_q <= redirect_pc_in & ~32'h3;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      slot_v_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      for (int i = int'(READ_LATENCY) - 1; i > 0; i--) begin
        slot_v_q[i]  <= slot_v_q[i-1];
        slot_pc_q[i] <= slot_pc_q[i-1];
      end
      slot_v_q[0]  <= issue;
      slot_pc_q[0] <= fetch_pc_q;
      if (push) begin
        buf_data_q[tail_q] <= imem_data_in;
        buf_pc_q[tail_q]   <= slot_pc_q[READ_LATENCY-1];
        tail_q             <= ptr_inc(tail_q);
      end
      if (pop) head_q <= ptr_inc(head_q);
    end
  end

  overflow_a: assert property (@(posedge clk_in) disable iff (rst_in || redirect_in)
    !(push && !pop && (count_q == CNT_W'(BUF_DEPTH))));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: startup/stall vector table, redirect and reset sequences,
// randomized traffic against an in-order PC stream model, and a small-memory wrap run.
module tb_fetch_unit;

  localparam int RL    = 2;
  localparam int BD    = 4;
  localparam int WORDS = 4096;
  localparam int AW    = 12;

  logic          clk = 1'b0;
  logic          rst, ready, redir;
  logic [31:0]   redir_pc;
  logic [AW-1:0] addr;
  logic          en, valid;
  logic [31:0]   rdata, instr, pc;
  logic [31:0]   p1 = 32'h0, p2 = 32'h0;

  logic          rst_w, ready_w, redir_w, en_w, valid_w;
  logic [3:0]    addr_w;
  logic [31:0]   rdata_w, instr_w, pc_w, redir_pc_w;
  logic [31:0]   q1 = 32'h0, q2 = 32'h0;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_pc, iss_pc;
  int outstanding, idle;

  always #5 clk = ~clk;

  fetch_unit u_dut (
    .clk_in(clk), .rst_in(rst), .imem_addr_out(addr), .imem_en_out(en),
    .imem_data_in(rdata), .iq_ready_in(ready), .valid_out(valid),
    .instruction_out(instr), .pc_out(pc), .redirect_in(redir), .redirect_pc_in(redir_pc)
  );

  fetch_unit #(.RESET_PC(32'h0000_0038), .IMEM_WORDS(16)) u_wrap (
    .clk_in(clk), .rst_in(rst_w), .imem_addr_out(addr_w), .imem_en_out(en_w),
    .imem_data_in(rdata_w), .iq_ready_in(ready_w), .valid_out(valid_w),
    .instruction_out(instr_w), .pc_out(pc_w), .redirect_in(redir_w), .redirect_pc_in(redir_pc_w)
  );

  // Two-stage BRAM models: mem[i] = A000_0000+i (main), B000_0000+i (wrap)
  always @(posedge clk) begin
    p1 <= en ? 32'hA000_0000 + 32'(addr) : 32'hDEAD_BEEF;
    p2 <= p1;
    q1 <= en_w ? 32'hB000_0000 + 32'(addr_w) : 32'hDEAD_BEEF;
    q2 <= q1;
  end
  assign rdata   = p2;
  assign rdata_w = q2;

  function automatic logic [31:0] exp_instr(input logic [31:0] p);
    return 32'hA000_0000 + ((p >> 2) & 32'(WORDS - 1));
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Sample at negedge and run the stream model: delivered pcs are contiguous from
  // the last reset/redirect target, issues in order, credit never exceeds BD.
  task automatic sample();
    logic xfer;
    @(negedge clk);
    xfer = valid && ready;
    if (rst) begin
      exp_pc = 32'h0; iss_pc = 32'h0; outstanding = 0; idle = 0;
    end else if (redir) begin
      chk("redirect_quiet", 96'({valid, en}), 96'(2'b00));
      exp_pc = redir_pc & ~32'h3; iss_pc = exp_pc; outstanding = 0; idle = 0;
    end else begin
      if (en) begin
        chk("issue_order", 96'({addr, (outstanding - int'(xfer)) < BD}),
            96'({iss_pc[AW+1:2], 1'b1}));
        iss_pc = iss_pc + 32'd4;
      end
      if (xfer) begin
        chk("deliver", 96'({pc, instr}), 96'({exp_pc, exp_instr(exp_pc)}));
        exp_pc = exp_pc + 32'd4;
      end
      outstanding = outstanding + int'(en) - int'(xfer);
      if (ready && !valid) begin
        idle++;
        chk("fill_latency", 96'(idle <= RL + 1), 96'(1));
      end else begin
        idle = 0;
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  typedef struct packed {
    logic          ready;
    logic          ev;
    logic          een;
    logic [AW-1:0] eaddr;
    logic [31:0]   epc;
  } vec_t;

  vec_t tbl [18];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic        got;
    logic [31:0] gpc, ginstr;
    logic [3:0]  wa [3];
    logic [31:0] wp [3];
    logic [31:0] wi [3];
    int na, np;

    // Startup then a 6-cycle queue stall: {ready, valid, en, addr, pc}
    tbl = '{
      '{1'b1, 1'b0, 1'b1, 12'd0,  32'h00}, '{1'b1, 1'b0, 1'b1, 12'd1,  32'h00},
      '{1'b1, 1'b0, 1'b1, 12'd2,  32'h00}, '{1'b1, 1'b1, 1'b1, 12'd3,  32'h00},
      '{1'b1, 1'b1, 1'b1, 12'd4,  32'h04}, '{1'b1, 1'b1, 1'b1, 12'd5,  32'h08},
      '{1'b0, 1'b1, 1'b1, 12'd6,  32'h0C}, '{1'b0, 1'b1, 1'b0, 12'd0,  32'h0C},
      '{1'b0, 1'b1, 1'b0, 12'd0,  32'h0C}, '{1'b0, 1'b1, 1'b0, 12'd0,  32'h0C},
      '{1'b0, 1'b1, 1'b0, 12'd0,  32'h0C}, '{1'b0, 1'b1, 1'b0, 12'd0,  32'h0C},
      '{1'b1, 1'b1, 1'b1, 12'd7,  32'h0C}, '{1'b1, 1'b1, 1'b1, 12'd8,  32'h10},
      '{1'b1, 1'b1, 1'b1, 12'd9,  32'h14}, '{1'b1, 1'b1, 1'b1, 12'd10, 32'h18},
      '{1'b1, 1'b1, 1'b1, 12'd11, 32'h1C}, '{1'b1, 1'b1, 1'b1, 12'd12, 32'h20}
    };

    rst = 1'b1; ready = 1'b1; redir = 1'b0; redir_pc = 32'h0;
    rst_w = 1'b1; ready_w = 1'b1; redir_w = 1'b0; redir_pc_w = 32'h0;
    exp_pc = 32'h0; iss_pc = 32'h0; outstanding = 0; idle = 0;
    tick();
    sample();
    chk("reset_state", 96'({valid, en, addr, pc, instr}), 96'({1'b0, 1'b0, 12'd0, 32'h0, 32'h0}));
    advance();
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      ready = tbl[i].ready;
      sample();
      chk($sformatf("table_row%0d", i),
          96'({valid, en, en ? addr : 12'd0, valid ? pc : 32'd0, valid ? instr : 32'd0}),
          96'({tbl[i].ev, tbl[i].een, tbl[i].een ? tbl[i].eaddr : 12'd0,
               tbl[i].ev ? tbl[i].epc : 32'd0, tbl[i].ev ? exp_instr(tbl[i].epc) : 32'd0}));
      advance();
    end

    // Redirect with two reads in flight and two entries buffered
    rst = 1'b1; ready = 1'b0;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    redir = 1'b1; redir_pc = 32'h0000_0043; ready = 1'b1;
    sample();
    chk("redirect_cycle", 96'({valid, en}), 96'(2'b00));
    advance();
    redir = 1'b0;
    sample();
    chk("redirect_first_issue", 96'({en, addr}), 96'({1'b1, 12'd16}));
    advance();
    got = 1'b0; gpc = 32'h0; ginstr = 32'h0;
    for (int k = 0; k < 8 && !got; k++) begin
      sample();
      if (valid && ready) begin got = 1'b1; gpc = pc; ginstr = instr; end
      advance();
    end
    chk("redirect_first_pc", 96'({got, gpc, ginstr}), 96'({1'b1, 32'h40, 32'hA000_0010}));
    repeat (6) tick();

    // Two redirects during a queue stall; only the last target is delivered
    ready = 1'b0;
    repeat (6) tick();
    redir = 1'b1; redir_pc = 32'h0000_0200;
    tick();
    redir = 1'b0;
    tick();
    redir = 1'b1; redir_pc = 32'h0000_0100;
    tick();
    redir = 1'b0; ready = 1'b1;
    got = 1'b0; gpc = 32'h0;
    for (int k = 0; k < 8 && !got; k++) begin
      sample();
      if (valid && ready) begin got = 1'b1; gpc = pc; end
      advance();
    end
    chk("double_redirect_pc", 96'({got, gpc}), 96'({1'b1, 32'h100}));
    repeat (6) tick();

    // Mid-stream reset with a coincident redirect
    rst = 1'b1; redir = 1'b1; redir_pc = 32'h0000_0500;
    sample();
    chk("reset_cycle_quiet", 96'({valid, en}), 96'(2'b00));
    advance();
    rst = 1'b0; redir = 1'b0;
    sample();
    chk("reset_values", 96'({valid, pc, instr, en, addr}), 96'({1'b0, 32'h0, 32'h0, 1'b1, 12'd0}));
    advance();
    got = 1'b0; gpc = 32'hFFFF_FFFF;
    for (int k = 0; k < 8 && !got; k++) begin
      sample();
      if (valid && ready) begin got = 1'b1; gpc = pc; end
      advance();
    end
    chk("reset_restart_pc", 96'({got, gpc}), 96'({1'b1, 32'h0}));

    // Randomized backpressure and redirects, including PC wrap at 2^32
    for (int c = 0; c < 1500; c++) begin
      ready = ($urandom_range(0, 9) < 7);
      redir = ($urandom_range(0, 39) == 0);
      redir_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31)))
                                             : 32'($urandom_range(0, 32'h0000_FFFF));
      tick();
    end
    redir = 1'b0; ready = 1'b1;
    repeat (8) tick();

    // Small memory: address wraps at IMEM_WORDS while pc keeps counting
    rst_w = 1'b1;
    tick();
    rst_w = 1'b0;
    na = 0; np = 0;
    for (int i = 0; i < 3; i++) begin wa[i] = 4'hF; wp[i] = 32'h0; wi[i] = 32'h0; end
    for (int k = 0; k < 12 && (na < 3 || np < 3); k++) begin
      sample();
      if (en_w && na < 3) begin wa[na] = addr_w; na++; end
      if (valid_w && np < 3) begin wp[np] = pc_w; wi[np] = instr_w; np++; end
      advance();
    end
    chk("wrap_addr", 96'({wa[0], wa[1], wa[2]}), 96'({4'd14, 4'd15, 4'd0}));
    chk("wrap_pc0", 96'({wp[0], wi[0]}), 96'({32'h38, 32'hB000_000E}));
    chk("wrap_pc1", 96'({wp[1], wi[1]}), 96'({32'h3C, 32'hB000_000F}));
    chk("wrap_pc2", 96'({wp[2], wi[2]}), 96'({32'h40, 32'hB000_0000}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
